ex_mdu_stage: RTL and testbench
===============================

// Module: ex_mdu_stage
// PURPOSE
//  Execute stage: ALU plus HI/LO multiply/divide unit. Ops: logic, shift, add/sub/compare,
//  HI/LO moves, iterative divide. Sits between ID/EX and EX/MEM and registers its result
//  (it absorbs the EX/MEM register). Asserts stallreq_o to freeze the upstream pipeline
//  while a divide runs.
// PARAMETERS
//  DATA_W      32  operand/result width; divide takes DATA_W iteration cycles
//  REG_ADDR_W  5   destination register address width
// PORTS
//  clk         in   1           single clock, rising edge
//  rst         in   1           reset, asynchronous, active-low
//  valid_i     in   1           decoded op present this cycle
//  aluop_i     in   8           operation code (shared package)
//  alusel_i    in   3           result class: LOGIC/SHIFT/ARITH/MOVE/NOP
//  reg1_i      in   DATA_W      operand 1 (shift amount in low log2(DATA_W) bits)
//  reg2_i      in   DATA_W      operand 2
//  wd_i        in   REG_ADDR_W  destination register
//  wreg_i      in   1           destination write enable
//  flush_i     in   1           kill in-flight op, including a running divide
//  stallreq_o  out  1           combinational; high while a divide is in progress
//  wd_o        out  REG_ADDR_W  registered destination
//  wreg_o      out  1           registered write enable
//  wdata_o     out  DATA_W      registered GPR result
//  whilo_o     out  1           registered HI/LO write strobe
//  hi_o, lo_o  out  DATA_W      architectural HI/LO registers
// BEHAVIOUR
//  - Reset (rst=0): every output and HI/LO goes to 0. FSM goes to IDLE. Reset mid-divide aborts the divide.
//  - Single-cycle ops: the result is registered at the next edge (latency 1).
//    valid_i=0 or flush_i=1 loads a bubble: wreg_o=0, whilo_o=0, wdata_o=0.
//  - Ops:
//    - LOGIC: OR/AND/XOR/NOR.
//    - SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[log2(DATA_W)-1:0].
//    - ARITH: ADDU/SUBU, with modulo 2^DATA_W wrap and no overflow trap; SLT is signed, SLTU is unsigned (result 0 or 1).
//    - MOVE: MFHI/MFLO write GPR. MTHI/MTLO write HI or LO at that edge and set wreg_o=0.
//    - An unknown op behaves as a bubble with wreg_o passed through and wdata_o=0.
//  - HI/LO update at the same edge whole-op results register. An MFHI/MFLO in the next cycle sees the new value.
//  - Divide FSM states: IDLE, BUSY, DONE.
//    - IDLE, DIV/DIVU with valid_i:
//      - divisor!=0: go to BUSY, stallreq_o=1 this cycle.
//      - divisor==0: go to DONE, stallreq_o=1 for exactly 1 cycle.
//    - BUSY: restoring shift-subtract on operand magnitudes, one bit per cycle.
//      A counter counts 0..DATA_W-1. The last iteration goes to DONE. stallreq_o=1 throughout.
//    - DONE: stallreq_o=0. At this edge: lo=quotient, hi=remainder, whilo_o=1, wreg_o=0. Then IDLE.
//    - Stall length: DATA_W+1 cycles. The result registers DATA_W+2 edges after issue.
//    - Upstream holds the inputs stable while stallreq_o=1.
//    - Signed divide: quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
//      MIN_INT / -1 gives quotient=MIN_INT (wrap), remainder=0.
//    - Divide by zero: quotient all-ones, remainder = dividend.
//    - flush_i in BUSY or DONE: go to IDLE, drop stallreq_o the same cycle, leave HI/LO unchanged.
//      Flush wins over a simultaneous DONE.
// CONFIGURATION
//  EX_MUL_EN defined: MULT/MULTU write the full 2*DATA_W product at the next edge (hi=upper,
//    lo=lower, whilo_o=1, no stall). MUL writes the low half to the GPR.
//  EX_MUL_EN undefined: no multiplier is instantiated. The three multiply ops behave as unknown ops;
//    HI/LO are unchanged.
// STRUCTURE
//  Shared package ex_defs: aluop/alusel codes, ZeroWord, DIV FSM state enum.
//  Sub-module ex_div: the iterative divider (start, signed, a, b, cancel -> busy, done, q, r).
//    The top level holds the ALU, HI/LO, output register and stall logic.
// TESTING
//  1 OR 0x0F0F0000|0x0000F0F0, wd_i=5 -> next edge: wdata_o=0x0F0FF0F0, wd_o=5, wreg_o=1.
//  2 SRA reg2=0x80000000, reg1=4 -> wdata_o=0xF8000000. SLT -1,1 -> 1. SLTU -1,1 -> 0.
//  3 DIV -7/2 -> stallreq_o high for 33 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF, whilo_o=1.
//  4 DIVU 9/0 -> 1 stall cycle, lo=0xFFFFFFFF, hi=9.
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5 DIVU issued, flush_i at cycle 10 -> stallreq_o low the same cycle, HI/LO unchanged.
//    rst=0 mid-divide -> all outputs 0.
//  6 With EX_MUL_EN: MULT 0xFFFFFFFF*2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU -> hi=1.
//    Without EX_MUL_EN: HI/LO unchanged.

Source files
------------

// File: rtl/ex_mdu_stage_pkg.sv
// Package ex_defs: shared definitions for the execute stage.
//   - ALU operation codes (aluop, 8 bits) and result classes (alusel, 3 bits)
//   - ZeroWord constant
//   - divider FSM state encoding (IDLE / BUSY / DONE)
// Optional feature macro used by the stage: EX_MUL_EN (multiply ops).
package ex_defs;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Result classes
  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  // Operation codes
  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;

  // Divider FSM states
  typedef logic [1:0] div_state_t;
  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/ex_mdu_stage_if.sv
// Interface ex_mdu_stage_if: decoded-op inputs from ID/EX, flush, stall request
// and the registered EX/MEM-side results of the execute stage.
//   slave  modport: the execute stage (consumes *_i, drives *_o)
//   master modport: the surrounding pipeline (drives *_i, consumes *_o)
interface ex_mdu_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  import ex_defs::*;

  logic                  valid_i;
  logic [7:0]            aluop_i;
  logic [2:0]            alusel_i;
  logic [DATA_W-1:0]     reg1_i;
  logic [DATA_W-1:0]     reg2_i;
  logic [REG_ADDR_W-1:0] wd_i;
  logic                  wreg_i;
  logic                  flush_i;
  logic                  stallreq_o;
  logic [REG_ADDR_W-1:0] wd_o;
  logic                  wreg_o;
  logic [DATA_W-1:0]     wdata_o;
  logic                  whilo_o;
  logic [DATA_W-1:0]     hi_o;
  logic [DATA_W-1:0]     lo_o;

  modport slave (
    input  valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    output stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
  );

  modport master (
    output valid_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
    input  stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o
  );

endinterface

// File: rtl/ex_mdu_stage_div.sv
// Module ex_div: iterative restoring divider, one quotient bit per cycle.
//   clk, rst (async, active-low)
//   start      : begin a divide (sampled only in IDLE)
//   signed_op  : treat a/b as two's-complement
//   a, b       : dividend, divisor
//   cancel     : abort from BUSY/DONE back to IDLE
//   busy       : iterations in progress
//   done       : result valid this cycle (one cycle)
//   q, r       : quotient / remainder with signs applied
// A zero divisor skips the iterations: quotient all-ones, remainder = dividend.
module ex_div
  import ex_defs::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] quo_reg;
  logic [DATA_W-1:0] rem_reg;
  logic [DATA_W-1:0] dsr_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;

  logic              a_neg;
  logic              b_neg;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W:0]   rem_shift;
  logic [DATA_W:0]   diff;
  logic              fits;

  // Magnitudes fit in DATA_W unsigned bits, including MIN_INT.
  assign a_neg = signed_op & a[DATA_W-1];
  assign b_neg = signed_op & b[DATA_W-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Bring the next dividend bit (MSB of quo_reg) into the partial remainder.
  assign rem_shift = {rem_reg, quo_reg[DATA_W-1]};
  assign diff      = rem_shift - {1'b0, dsr_reg};
  assign fits      = ~diff[DATA_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      quo_reg   <= '0;
      rem_reg   <= '0;
      dsr_reg   <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (start) begin
            cnt_reg <= '0;
            dsr_reg <= b_mag;
            if (b == '0) begin
              quo_reg   <= '1;
              rem_reg   <= a;
              neg_q_reg <= 1'b0;
              neg_r_reg <= 1'b0;
              state_reg <= DIV_DONE;
            end else begin
              quo_reg   <= a_mag;
              rem_reg   <= '0;
              neg_q_reg <= a_neg ^ b_neg;
              neg_r_reg <= a_neg;
              state_reg <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (cancel) begin
            state_reg <= DIV_IDLE;
          end else begin
            rem_reg <= fits ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            quo_reg <= {quo_reg[DATA_W-2:0], fits};
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == CNT_W'(DATA_W - 1)) begin
              state_reg <= DIV_DONE;
            end
          end
        end
        DIV_DONE: state_reg <= DIV_IDLE;
        default:  state_reg <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state_reg == DIV_BUSY);
  assign done = (state_reg == DIV_DONE);
  // MIN_INT / -1 lands here with neg_q=0 and quo=MIN_INT, which is the wrapped result.
  assign q    = neg_q_reg ? (~quo_reg + 1'b1) : quo_reg;
  assign r    = neg_r_reg ? (~rem_reg + 1'b1) : rem_reg;

endmodule

// File: rtl/ex_mdu_stage.sv
// Module ex_mdu_stage: execute stage with ALU, HI/LO registers, iterative
// divider and (optionally) a multiplier; absorbs the EX/MEM register.
//   clk, rst (async, active-low)
//   bus (slave): valid/aluop/alusel/reg1/reg2/wd/wreg/flush in;
//                stallreq (combinational), wd/wreg/wdata/whilo/hi/lo out.
// Macro EX_MUL_EN: when defined, MULT/MULTU write HI/LO with the full product
// and MUL writes the low half to the GPR; otherwise they act as unknown ops.
module ex_mdu_stage
  import ex_defs::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  ex_mdu_stage_if.slave    bus
);

  localparam int SH_W = $clog2(DATA_W);

  logic [REG_ADDR_W-1:0] wd_reg,    wd_next;
  logic                  wreg_reg,  wreg_next;
  logic [DATA_W-1:0]     wdata_reg, wdata_next;
  logic                  whilo_reg, whilo_next;
  logic [DATA_W-1:0]     hi_reg,    hi_next;
  logic [DATA_W-1:0]     lo_reg,    lo_next;

  logic                  is_div;
  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic                  div_idle;
  logic [DATA_W-1:0]     div_q;
  logic [DATA_W-1:0]     div_r;
  logic [DATA_W-1:0]     alu_res;
  logic [SH_W-1:0]       sh;

`ifdef EX_MUL_EN
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]        prod_u;
  assign prod_s = $signed(bus.reg1_i) * $signed(bus.reg2_i);
  assign prod_u = {{DATA_W{1'b0}}, bus.reg1_i} * {{DATA_W{1'b0}}, bus.reg2_i};
`endif

  assign sh       = bus.reg1_i[SH_W-1:0];
  assign is_div   = bus.valid_i & is_div_op(bus.aluop_i);
  assign div_idle = ~div_busy & ~div_done;
  // A divide starts only from IDLE; the DONE cycle still shows the same op.
  assign div_start = is_div & ~bus.flush_i & div_idle;
  // Gated by rst so the stall request is low while reset is held.
  assign bus.stallreq_o = rst & (div_start | (div_busy & ~bus.flush_i));

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (bus.aluop_i == OP_DIV),
    .a         (bus.reg1_i),
    .b         (bus.reg2_i),
    .cancel    (bus.flush_i),
    .busy      (div_busy),
    .done      (div_done),
    .q         (div_q),
    .r         (div_r)
  );

  // GPR result by class; an op not recognised within its class yields zero.
  always_comb begin
    alu_res = '0;
    case (bus.alusel_i)
      SEL_LOGIC: begin
        case (bus.aluop_i)
          OP_OR:   alu_res = bus.reg1_i | bus.reg2_i;
          OP_AND:  alu_res = bus.reg1_i & bus.reg2_i;
          OP_XOR:  alu_res = bus.reg1_i ^ bus.reg2_i;
          OP_NOR:  alu_res = ~(bus.reg1_i | bus.reg2_i);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (bus.aluop_i)
          OP_SLL:  alu_res = bus.reg2_i << sh;
          OP_SRL:  alu_res = bus.reg2_i >> sh;
          OP_SRA:  alu_res = $signed(bus.reg2_i) >>> sh;
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (bus.aluop_i)
          OP_ADDU: alu_res = bus.reg1_i + bus.reg2_i;
          OP_SUBU: alu_res = bus.reg1_i - bus.reg2_i;
          OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
          OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, bus.reg1_i < bus.reg2_i};
`ifdef EX_MUL_EN
          OP_MUL:  alu_res = prod_s[DATA_W-1:0];
`endif
          default: alu_res = '0;
        endcase
      end
      SEL_MOVE: begin
        case (bus.aluop_i)
          OP_MFHI: alu_res = hi_reg;
          OP_MFLO: alu_res = lo_reg;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  // Next values of the output register and HI/LO. Flush and the issue/busy
  // cycles of a divide load a bubble.
  always_comb begin
    wd_next    = '0;
    wreg_next  = 1'b0;
    wdata_next = '0;
    whilo_next = 1'b0;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    if (!bus.flush_i) begin
      if (div_done) begin
        wd_next    = bus.wd_i;
        whilo_next = 1'b1;
        hi_next    = div_r;
        lo_next    = div_q;
      end else if (bus.valid_i && !is_div) begin
        wd_next   = bus.wd_i;
        wreg_next = bus.wreg_i;
        case (bus.aluop_i)
          OP_MTHI: begin
            wreg_next  = 1'b0;
            whilo_next = 1'b1;
            hi_next    = bus.reg1_i;
          end
          OP_MTLO: begin
            wreg_next  = 1'b0;
            whilo_next = 1'b1;
            lo_next    = bus.reg1_i;
          end
`ifdef EX_MUL_EN
          OP_MULT: begin
            wreg_next  = 1'b0;
            whilo_next = 1'b1;
            hi_next    = prod_s[2*DATA_W-1:DATA_W];
            lo_next    = prod_s[DATA_W-1:0];
          end
          OP_MULTU: begin
            wreg_next  = 1'b0;
            whilo_next = 1'b1;
            hi_next    = prod_u[2*DATA_W-1:DATA_W];
            lo_next    = prod_u[DATA_W-1:0];
          end
`endif
          default: wdata_next = alu_res;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_reg    <= '0;
      wreg_reg  <= 1'b0;
      wdata_reg <= '0;
      whilo_reg <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      wd_reg    <= wd_next;
      wreg_reg  <= wreg_next;
      wdata_reg <= wdata_next;
      whilo_reg <= whilo_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  assign bus.wd_o    = wd_reg;
  assign bus.wreg_o  = wreg_reg;
  assign bus.wdata_o = wdata_reg;
  assign bus.whilo_o = whilo_reg;
  assign bus.hi_o    = hi_reg;
  assign bus.lo_o    = lo_reg;

endmodule

// File: tb/tb_ex_mdu_stage.sv
module tb_ex_mdu_stage;
  import ex_defs::*;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] hi_m;
  logic [31:0] lo_m;

  typedef struct {
    string       tag;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  ex_mdu_stage_if #(.DATA_W(32), .REG_ADDR_W(5)) bus ();

  ex_mdu_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic we, input logic fl);
    bus.valid_i  = v;
    bus.aluop_i  = op;
    bus.alusel_i = sel;
    bus.reg1_i   = a;
    bus.reg2_i   = b;
    bus.wd_i     = wd;
    bus.wreg_i   = we;
    bus.flush_i  = fl;
  endtask

  // Pop the oldest expectation and compare it against the registered outputs.
  task automatic compare_pop();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "/wdata"}, bus.wdata_o, e.wdata);
    check({e.tag, "/wreg"},  {31'd0, bus.wreg_o}, {31'd0, e.wreg});
    check({e.tag, "/whilo"}, {31'd0, bus.whilo_o}, {31'd0, e.whilo});
    check({e.tag, "/hi"},    bus.hi_o, e.hi);
    check({e.tag, "/lo"},    bus.lo_o, e.lo);
    if (e.wreg) check({e.tag, "/wd"}, {27'd0, bus.wd_o}, {27'd0, e.wd});
    $display("txn %s: wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h",
             e.tag, bus.wd_o, bus.wreg_o, bus.wdata_o, bus.whilo_o, bus.hi_o, bus.lo_o);
  endtask

  // Single-cycle op: drive, push expectation, one edge, compare.
  task automatic op1(input string tag, input logic v, input logic [7:0] op, input logic [2:0] sel,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                     input logic we, input logic fl, input logic [31:0] exp_data,
                     input logic exp_wreg, input logic exp_whilo);
    drive(v, op, sel, a, b, wd, we, fl);
    sb.push_back('{tag, wd, exp_wreg, exp_data, exp_whilo, hi_m, lo_m});
    @(posedge clk); #1;
    compare_pop();
  endtask

  // Reference divide (behavioural, via the language's / and % operators).
  function automatic void div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sgn) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall,
                        input logic [31:0] exp_q, input logic [31:0] exp_r);
    int n;
    drive(1'b1, op, SEL_NOP, a, b, 5'd0, 1'b0, 1'b0);
    sb.push_back('{tag, 5'd0, 1'b0, 32'd0, 1'b1, exp_r, exp_q});
    n = 0;
    #1;
    while (bus.stallreq_o === 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "/stall_cycles"}, 32'(n), 32'(exp_stall));
    @(posedge clk); #1;
    compare_pop();
    hi_m = exp_r;
    lo_m = exp_q;
    drive(1'b0, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] q_m;
    logic [31:0] r_m;
    logic [31:0] ra;
    logic [31:0] rb;

    hi_m = 32'd0;
    lo_m = 32'd0;
    rst  = 1'b0;
    drive(1'b0, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset/wdata", bus.wdata_o, 32'd0);
    check("reset/wreg",  {31'd0, bus.wreg_o}, 32'd0);
    check("reset/whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("reset/hi",    bus.hi_o, 32'd0);
    check("reset/lo",    bus.lo_o, 32'd0);
    check("reset/stall", {31'd0, bus.stallreq_o}, 32'd0);
    rst = 1'b1;

    // Logic / shift / arithmetic
    op1("or",   1, OP_OR,   SEL_LOGIC, 32'h0F0F_0000, 32'h0000_F0F0, 5'd5, 1, 0, 32'h0F0F_F0F0, 1, 0);
    op1("and",  1, OP_AND,  SEL_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd6, 1, 0, 32'h0F00_0F00, 1, 0);
    op1("xor",  1, OP_XOR,  SEL_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd7, 1, 0, 32'h5555_5555, 1, 0);
    op1("nor",  1, OP_NOR,  SEL_LOGIC, 32'h0000_00F0, 32'h0000_000F, 5'd8, 1, 0, 32'hFFFF_FF00, 1, 0);
    op1("sra",  1, OP_SRA,  SEL_SHIFT, 32'd4,  32'h8000_0000, 5'd9, 1, 0, 32'hF800_0000, 1, 0);
    op1("srl",  1, OP_SRL,  SEL_SHIFT, 32'd4,  32'h8000_0000, 5'd9, 1, 0, 32'h0800_0000, 1, 0);
    op1("sll",  1, OP_SLL,  SEL_SHIFT, 32'd35, 32'h0000_0001, 5'd9, 1, 0, 32'h0000_0008, 1, 0);
    op1("slt",  1, OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd10, 1, 0, 32'd1, 1, 0);
    op1("sltu", 1, OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1, 5'd10, 1, 0, 32'd0, 1, 0);
    op1("addu_wrap", 1, OP_ADDU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd11, 1, 0, 32'd1, 1, 0);
    op1("subu_wrap", 1, OP_SUBU, SEL_ARITH, 32'd0, 32'd1, 5'd11, 1, 0, 32'hFFFF_FFFF, 1, 0);
    op1("unknown",   1, 8'hEE, SEL_LOGIC, 32'h1234_5678, 32'h1, 5'd12, 1, 0, 32'd0, 1, 0);
    op1("bubble",    0, OP_OR, SEL_LOGIC, 32'h1234_5678, 32'h1, 5'd12, 1, 0, 32'd0, 0, 0);
    op1("flush",     1, OP_OR, SEL_LOGIC, 32'h1234_5678, 32'h1, 5'd12, 1, 1, 32'd0, 0, 0);

    // HI/LO moves
    hi_m = 32'hCAFE_0001;
    op1("mthi", 1, OP_MTHI, SEL_MOVE, 32'hCAFE_0001, 32'd0, 5'd0, 0, 0, 32'd0, 0, 1);
    lo_m = 32'hBEEF_0002;
    op1("mtlo", 1, OP_MTLO, SEL_MOVE, 32'hBEEF_0002, 32'd0, 5'd0, 0, 0, 32'd0, 0, 1);
    op1("mfhi", 1, OP_MFHI, SEL_MOVE, 32'd0, 32'd0, 5'd13, 1, 0, 32'hCAFE_0001, 1, 0);
    op1("mflo", 1, OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd14, 1, 0, 32'hBEEF_0002, 1, 0);

    // Divides
    do_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("divu_9_0",   OP_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9);
    do_div("div_min_m1", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    ra = $urandom;
    rb = $urandom_range(1, 32'h0001_0000);
    div_model(1'b0, ra, rb, q_m, r_m);
    do_div("divu_rand", OP_DIVU, ra, rb, 33, q_m, r_m);
    ra = $urandom;
    rb = $urandom | 32'h8000_0000;
    div_model(1'b1, ra, rb, q_m, r_m);
    do_div("div_rand", OP_DIV, ra, rb, 33, q_m, r_m);

    // Flush a running divide at cycle 10
    drive(1'b1, OP_DIVU, SEL_NOP, 32'd1000, 32'd3, 5'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("flush_div/stall_before", {31'd0, bus.stallreq_o}, 32'd1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_div/stall_drop", {31'd0, bus.stallreq_o}, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    check("flush_div/whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("flush_div/hi", bus.hi_o, hi_m);
    check("flush_div/lo", bus.lo_o, lo_m);
    @(posedge clk); #1;
    check("flush_div/idle", {31'd0, bus.stallreq_o}, 32'd0);
    do_div("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // Reset in the middle of a divide
    drive(1'b1, OP_DIV, SEL_NOP, 32'd50, 32'd5, 5'd0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid/hi",    bus.hi_o, 32'd0);
    check("rst_mid/lo",    bus.lo_o, 32'd0);
    check("rst_mid/whilo", {31'd0, bus.whilo_o}, 32'd0);
    check("rst_mid/wreg",  {31'd0, bus.wreg_o}, 32'd0);
    check("rst_mid/wdata", bus.wdata_o, 32'd0);
    check("rst_mid/stall", {31'd0, bus.stallreq_o}, 32'd0);
    drive(1'b0, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst  = 1'b1;
    hi_m = 32'd0;
    lo_m = 32'd0;
    op1("mflo_after_rst", 1, OP_MFLO, SEL_MOVE, 32'd0, 32'd0, 5'd3, 1, 0, 32'd0, 1, 0);
    do_div("divu_after_rst", OP_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 32'd9);

    // Multiply
`ifdef EX_MUL_EN
    hi_m = 32'hFFFF_FFFF;
    lo_m = 32'hFFFF_FFFE;
    op1("mult",  1, OP_MULT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, 32'd0, 0, 1);
    hi_m = 32'd1;
    lo_m = 32'hFFFF_FFFE;
    op1("multu", 1, OP_MULTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, 32'd0, 0, 1);
    op1("mul",   1, OP_MUL,   SEL_ARITH, 32'hFFFF_FFFF, 32'd3, 5'd4, 1, 0, 32'hFFFF_FFFD, 1, 0);
`else
    op1("mult",  1, OP_MULT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, 32'd0, 0, 0);
    op1("multu", 1, OP_MULTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, 32'd0, 0, 0);
    op1("mul",   1, OP_MUL,   SEL_ARITH, 32'hFFFF_FFFF, 32'd3, 5'd4, 1, 0, 32'd0, 1, 0);
`endif

    drive(1'b0, OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
